alarm_set_controller: RTL and testbench
=======================================

ALARM_SET_CONTROLLER -- requirements
Module: alarm_set_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_TICKS, default 30, edit-inactivity abort limit in seconds.
REQ-002 SHALL have clock  in  1  100 MHz system clock; one clock domain only.
REQ-003 SHALL have reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have tick_1s  in  1  one-cycle pulse per second, coincident with the clock core's 1 s edge.
REQ-005 SHALL have btn_mode, btn_next, btn_up  in  1 each  debounced one-cycle button pulses.
REQ-006 SHALL have cur_hour1 in 2, cur_hour0/cur_min1/cur_min0 in 4 each  current time digits from the clock core.
REQ-007 SHALL have alarm_active  in  1  Alarm output of the clock core.
REQ-008 SHALL have hour_in1 out 2, hour_in0/minute_in1/minute_in0 out 4 each  edited digits to the clock core.
REQ-009 SHALL have load_time, load_alarm, stop_alarm  out  1 each  held commands to the clock core.
REQ-010 SHALL have in_edit out 1 (edit session active), edit_digit out 2 (0=H1,1=H0,2=M1,3=M0, for display blink).

Function
REQ-011 FSM states SHALL be IDLE, EDIT_H1, EDIT_H0, EDIT_M1, EDIT_M0, COMMIT, STOP_HOLD.
REQ-012 Button priority per cycle SHALL be mode > next > up; lower-priority pulses in the same cycle are ignored.
REQ-013 IDLE+btn_mode SHALL enter EDIT_H1, target=TIME, digits preloaded from cur_* that cycle.
REQ-014 IDLE+btn_next SHALL enter EDIT_H1, target=ALARM, digits preloaded from the alarm shadow register.
REQ-015 btn_up SHALL increment the selected digit with wrap: H1 0..2, M1 0..5, M0 0..9, H0 0..9 (0..3 when H1=2).
REQ-016 btn_next SHALL advance H1->H0->M1->M0->COMMIT; leaving EDIT_H1 with H1=2 and H0>3 SHALL clamp H0 to 3.
REQ-017 btn_mode in any EDIT state SHALL abort to IDLE with no load asserted.
REQ-018 TIMEOUT_TICKS tick_1s pulses with no button in EDIT states SHALL abort to IDLE; any button restarts the count.
REQ-019 COMMIT SHALL hold load_time (target TIME) or load_alarm (target ALARM) high, digits stable, every cycle.
REQ-020 tick_1s in the first COMMIT cycle SHALL be ignored; the first qualifying tick_1s SHALL move to IDLE next cycle, load low.
REQ-021 Committing target ALARM SHALL copy digits into the alarm shadow register on COMMIT exit.
REQ-022 Any button while alarm_active=1 SHALL enter STOP_HOLD from any state except COMMIT, consuming the button.
REQ-023 Entering STOP_HOLD from an EDIT state SHALL discard the edit session.
REQ-024 STOP_HOLD SHALL hold stop_alarm high; exit to IDLE follows the same tick rule as REQ-020.
REQ-025 load_time, load_alarm, stop_alarm SHALL be mutually exclusive and registered (no glitches).
REQ-026 in_edit SHALL be 1 exactly in EDIT_* states; edit_digit SHALL be 0 outside them.

Reset
REQ-027 Reset SHALL force IDLE, all outputs 0, target=TIME, timeout count 0.
REQ-028 Reset SHALL set the alarm shadow register to 2,4,0,0.
REQ-029 Reset asserted mid-COMMIT or mid-STOP_HOLD SHALL drop the held command immediately.

Structure
REQ-030 Shared package alarm_pkg SHALL hold the state enum, target enum, digit limits (2,9,3,5,9), TIMEOUT_TICKS default.
REQ-031 Sub-module tick_hold SHALL implement the hold-until-qualified-tick handshake; instantiated once, shared by COMMIT and STOP_HOLD.

Verification
REQ-032 cur=13:47, btn_mode, 3x btn_next, 2x btn_up, btn_next -> load_time high with digits 1,3,4,9 until first tick after COMMIT entry, then low.
REQ-033 btn_next in IDLE, H1 up twice (=2), preset H0=7, btn_next -> H0 reads 3; commit -> load_alarm with 2,3,x,x, shadow updated.
REQ-034 EDIT_M1 at 5, btn_up -> 0; EDIT_H0 with H1=2 at 3, btn_up -> 0.
REQ-035 In EDIT, 30 ticks with no button -> IDLE, in_edit=0, no load pulse ever.
REQ-036 alarm_active=1, btn_up in EDIT_M0 -> STOP_HOLD, stop_alarm high until next qualified tick; digits unchanged, no load.
REQ-037 Reset pulse mid-COMMIT -> load_* low same cycle, shadow = 2,4,0,0, state IDLE.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and limits for the alarm/time set controller.
package alarm_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StEditH1,
    StEditH0,
    StEditM1,
    StEditM0,
    StCommit,
    StStopHold
  } state_e;

  typedef enum logic {
    TgtTime,
    TgtAlarm
  } target_e;

  localparam int unsigned H1Max               = 2;
  localparam int unsigned H0Max               = 9;
  localparam int unsigned H0MaxAt2            = 3;
  localparam int unsigned M1Max               = 5;
  localparam int unsigned M0Max               = 9;
  localparam int unsigned DefaultTimeoutTicks = 30;

  function automatic logic [3:0] inc_wrap(logic [3:0] d, int unsigned max);
    return (32'(d) >= max) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/alarm_set_controller_if.sv
// Button/time-digit/command bundle between the clock core side and the set controller.
interface alarm_set_controller_if;
  logic       tick_1s;
  logic       btn_mode;
  logic       btn_next;
  logic       btn_up;
  logic [1:0] cur_hour1;
  logic [3:0] cur_hour0;
  logic [3:0] cur_min1;
  logic [3:0] cur_min0;
  logic       alarm_active;
  logic [1:0] hour_in1;
  logic [3:0] hour_in0;
  logic [3:0] minute_in1;
  logic [3:0] minute_in0;
  logic       load_time;
  logic       load_alarm;
  logic       stop_alarm;
  logic       in_edit;
  logic [1:0] edit_digit;

  modport master (
    output tick_1s, btn_mode, btn_next, btn_up, cur_hour1, cur_hour0, cur_min1, cur_min0,
           alarm_active,
    input  hour_in1, hour_in0, minute_in1, minute_in0, load_time, load_alarm, stop_alarm,
           in_edit, edit_digit
  );

  modport slave (
    input  tick_1s, btn_mode, btn_next, btn_up, cur_hour1, cur_hour0, cur_min1, cur_min0,
           alarm_active,
    output hour_in1, hour_in0, minute_in1, minute_in0, load_time, load_alarm, stop_alarm,
           in_edit, edit_digit
  );
endinterface

// File: rtl/tick_hold.sv
// Releases a held command on the first tick_1s after the hold's first cycle.
module tick_hold (
  input  logic clock,
  input  logic reset,
  input  logic hold,
  input  logic tick_1s,
  output logic done
);

  logic armed_q;

  // armed_q lags hold by one cycle, so a tick in the entry cycle is ignored.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= hold;
    end
  end

  assign done = hold & armed_q & tick_1s;

endmodule

// File: rtl/alarm_set_controller.sv
// Button-driven time/alarm editor producing held load and stop commands for the clock core.
module alarm_set_controller
  import alarm_pkg::*;
#(
  parameter int unsigned TIMEOUT_TICKS = DefaultTimeoutTicks
) (
  input logic             clock,
  input logic             reset,
  alarm_set_controller_if.slave bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT_TICKS + 1);

  state_e          state_q, state_d;
  target_e         target_q, target_d;
  logic [1:0]      h1_q, h1_d, sh_h1_q, sh_h1_d;
  logic [3:0]      h0_q, h0_d, m1_q, m1_d, m0_q, m0_d;
  logic [3:0]      sh_h0_q, sh_h0_d, sh_m1_q, sh_m1_d, sh_m0_q, sh_m0_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            load_time_q, load_alarm_q, stop_alarm_q, in_edit_q;
  logic [1:0]      edit_digit_q, edit_digit_d;
  logic            any_btn, stop_req, hold_done;

  tick_hold u_tick_hold (
    .clock   (clock),
    .reset   (reset),
    .hold    ((state_q == StCommit) || (state_q == StStopHold)),
    .tick_1s (bus.tick_1s),
    .done    (hold_done)
  );

  function automatic logic is_edit(state_e s);
    return (s == StEditH1) || (s == StEditH0) || (s == StEditM1) || (s == StEditM0);
  endfunction

  assign any_btn  = bus.btn_mode | bus.btn_next | bus.btn_up;
  assign stop_req = bus.alarm_active & any_btn;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    h1_d     = h1_q;
    h0_d     = h0_q;
    m1_d     = m1_q;
    m0_d     = m0_q;
    sh_h1_d  = sh_h1_q;
    sh_h0_d  = sh_h0_q;
    sh_m1_d  = sh_m1_q;
    sh_m0_d  = sh_m0_q;
    cnt_d    = (is_edit(state_q) && bus.tick_1s) ? cnt_q + 1'b1 : cnt_q;

    case (state_q)
      StIdle: begin
        if (stop_req) begin
          state_d = StStopHold;
        end else if (bus.btn_mode) begin
          state_d  = StEditH1;
          target_d = TgtTime;
          h1_d     = bus.cur_hour1;
          h0_d     = bus.cur_hour0;
          m1_d     = bus.cur_min1;
          m0_d     = bus.cur_min0;
        end else if (bus.btn_next) begin
          state_d  = StEditH1;
          target_d = TgtAlarm;
          h1_d     = sh_h1_q;
          h0_d     = sh_h0_q;
          m1_d     = sh_m1_q;
          m0_d     = sh_m0_q;
        end
      end
      StEditH1, StEditH0, StEditM1, StEditM0: begin
        if (stop_req) begin
          state_d = StStopHold;
        end else if (bus.btn_mode) begin
          state_d = StIdle;
        end else if (bus.btn_next) begin
          cnt_d = '0;
          unique case (state_q)
            StEditH1: begin
              state_d = StEditH0;
              // Leaving H1 at 2 must not leave an illegal 24..29 hour behind.
              if (h1_q == 2'(H1Max) && h0_q > 4'(H0MaxAt2)) h0_d = 4'(H0MaxAt2);
            end
            StEditH0: state_d = StEditM1;
            StEditM1: state_d = StEditM0;
            default:  state_d = StCommit;
          endcase
        end else if (bus.btn_up) begin
          cnt_d = '0;
          unique case (state_q)
            StEditH1: h1_d = 2'(inc_wrap({2'b00, h1_q}, H1Max));
            StEditH0: h0_d = inc_wrap(h0_q, (h1_q == 2'(H1Max)) ? H0MaxAt2 : H0Max);
            StEditM1: m1_d = inc_wrap(m1_q, M1Max);
            default:  m0_d = inc_wrap(m0_q, M0Max);
          endcase
        end else if (bus.tick_1s && cnt_q == CntW'(TIMEOUT_TICKS - 1)) begin
          state_d = StIdle;
        end
      end
      StCommit: begin
        if (hold_done) begin
          state_d = StIdle;
          if (target_q == TgtAlarm) begin
            sh_h1_d = h1_q;
            sh_h0_d = h0_q;
            sh_m1_d = m1_q;
            sh_m0_d = m0_q;
          end
        end
      end
      StStopHold: begin
        if (!stop_req && hold_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (!is_edit(state_d)) cnt_d = '0;

    case (state_d)
      StEditH0: edit_digit_d = 2'd1;
      StEditM1: edit_digit_d = 2'd2;
      StEditM0: edit_digit_d = 2'd3;
      default:  edit_digit_d = 2'd0;
    endcase
  end

  // Commands are registered from the next state so they track state_q glitch-free.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      target_q     <= TgtTime;
      h1_q         <= '0;
      h0_q         <= '0;
      m1_q         <= '0;
      m0_q         <= '0;
      sh_h1_q      <= 2'd2;
      sh_h0_q      <= 4'd4;
      sh_m1_q      <= 4'd0;
      sh_m0_q      <= 4'd0;
      cnt_q        <= '0;
      load_time_q  <= 1'b0;
      load_alarm_q <= 1'b0;
      stop_alarm_q <= 1'b0;
      in_edit_q    <= 1'b0;
      edit_digit_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      h1_q         <= h1_d;
      h0_q         <= h0_d;
      m1_q         <= m1_d;
      m0_q         <= m0_d;
      sh_h1_q      <= sh_h1_d;
      sh_h0_q      <= sh_h0_d;
      sh_m1_q      <= sh_m1_d;
      sh_m0_q      <= sh_m0_d;
      cnt_q        <= cnt_d;
      load_time_q  <= (state_d == StCommit) && (target_d == TgtTime);
      load_alarm_q <= (state_d == StCommit) && (target_d == TgtAlarm);
      stop_alarm_q <= (state_d == StStopHold);
      in_edit_q    <= is_edit(state_d);
      edit_digit_q <= edit_digit_d;
    end
  end

  assign bus.hour_in1   = h1_q;
  assign bus.hour_in0   = h0_q;
  assign bus.minute_in1 = m1_q;
  assign bus.minute_in0 = m0_q;
  assign bus.load_time  = load_time_q;
  assign bus.load_alarm = load_alarm_q;
  assign bus.stop_alarm = stop_alarm_q;
  assign bus.in_edit    = in_edit_q;
  assign bus.edit_digit = edit_digit_q;

endmodule

// File: tb/tb_alarm_set_controller.sv
// Directed bench for alarm_set_controller: time/alarm edits, wraps, clamp, timeout, stop, reset.
module tb_alarm_set_controller;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic load_seen = 1'b0;

  alarm_set_controller_if bus ();

  alarm_set_controller #(
    .TIMEOUT_TICKS (30)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (bus.load_time || bus.load_alarm) load_seen = 1'b1;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] digits();
    return {2'b00, bus.hour_in1, bus.hour_in0, bus.minute_in1, bus.minute_in0};
  endfunction

  function automatic logic [15:0] cmds();
    return {11'd0, bus.load_time, bus.load_alarm, bus.stop_alarm, bus.in_edit, 1'b0};
  endfunction

  // One-cycle pulse starting at the current negedge; returns at the next negedge.
  task automatic step(input logic m, input logic n, input logic u, input logic t);
    bus.btn_mode = m;
    bus.btn_next = n;
    bus.btn_up   = u;
    bus.tick_1s  = t;
    @(negedge clock);
    bus.btn_mode = 1'b0;
    bus.btn_next = 1'b0;
    bus.btn_up   = 1'b0;
    bus.tick_1s  = 1'b0;
  endtask

  task automatic set_cur(input logic [15:0] t);
    bus.cur_hour1 = t[13:12];
    bus.cur_hour0 = t[11:8];
    bus.cur_min1  = t[7:4];
    bus.cur_min0  = t[3:0];
  endtask

  initial begin
    bus.btn_mode = 1'b0;
    bus.btn_next = 1'b0;
    bus.btn_up   = 1'b0;
    bus.tick_1s  = 1'b0;
    bus.alarm_active = 1'b0;
    set_cur(16'h1347);
    @(negedge clock);
    @(negedge clock);
    check("reset_cmds", cmds(), 16'h0);
    check("reset_digits", digits(), 16'h0);
    check("reset_edit_digit", 16'(bus.edit_digit), 16'h0);
    reset = 1'b0;

    // Time edit 13:47 -> 13:49, commit, tick handshake
    step(1, 0, 0, 0);
    check("mode_enters_edit", cmds(), 16'h0002);
    check("mode_preload", digits(), 16'h1347);
    step(0, 1, 0, 0);
    check("h0_edit_digit", 16'(bus.edit_digit), 16'h1);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    check("m0_edit_digit", 16'(bus.edit_digit), 16'h3);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    check("commit_load_time", cmds(), 16'h0010);
    check("commit_digits", digits(), 16'h1349);
    check("commit_edit_digit", 16'(bus.edit_digit), 16'h0);
    step(0, 0, 0, 1);
    check("first_cycle_tick_ignored", cmds(), 16'h0010);
    step(0, 0, 0, 0);
    check("commit_held", cmds(), 16'h0010);
    step(0, 0, 0, 1);
    check("commit_released", cmds(), 16'h0);

    // Alarm edit: 24:00 -> 07:00 to preset H0=7
    step(0, 1, 0, 0);
    check("alarm_preload_reset_shadow", digits(), 16'h2400);
    step(0, 0, 1, 0);
    check("h1_wrap_2_to_0", digits(), 16'h0400);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    check("alarm_commit_load_alarm", cmds(), 16'h0008);
    check("alarm_commit_digits", digits(), 16'h0700);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check("alarm_commit_released", cmds(), 16'h0);

    // Clamp: H1 0->2 with H0=7, leaving H1 clamps H0 to 3
    step(0, 1, 0, 0);
    check("shadow_0700", digits(), 16'h0700);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    check("h1_up_to_2", digits(), 16'h2700);
    step(0, 1, 0, 0);
    check("h0_clamped", digits(), 16'h2300);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    check("clamp_commit_load_alarm", cmds(), 16'h0008);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check("clamp_commit_released", cmds(), 16'h0);
    step(0, 1, 0, 0);
    check("shadow_2300", digits(), 16'h2300);
    step(1, 0, 0, 0);
    check("mode_abort", cmds(), 16'h0);

    // Wraps: M1 5->0, H0 3->0 with H1=2
    set_cur(16'h1357);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    check("m1_edit_digit", 16'(bus.edit_digit), 16'h2);
    step(0, 0, 1, 0);
    check("m1_wrap", digits(), 16'h1307);
    step(1, 0, 0, 0);
    set_cur(16'h2300);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    check("h0_wrap_at_2x", digits(), 16'h2000);
    step(1, 0, 0, 0);

    // Priority: mode wins over up in the same cycle
    set_cur(16'h1347);
    step(1, 0, 1, 0);
    check("mode_over_up", digits(), 16'h1347);

    // Timeout with a restart from btn_up
    load_seen = 1'b0;
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1);
    check("still_edit_after_20", cmds(), 16'h0002);
    step(0, 0, 1, 0);
    for (int i = 0; i < 29; i++) step(0, 0, 0, 1);
    check("still_edit_after_29", cmds(), 16'h0002);
    step(0, 0, 0, 1);
    check("timeout_idle", cmds(), 16'h0);
    check("timeout_edit_digit", 16'(bus.edit_digit), 16'h0);
    check("timeout_no_load", 16'(load_seen), 16'h0);

    // Stop while alarm sounds in EDIT_M0
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    bus.alarm_active = 1'b1;
    step(0, 0, 1, 0);
    bus.alarm_active = 1'b0;
    check("stop_hold_entry", cmds(), 16'h0004);
    check("stop_digits_kept", digits(), 16'h1347);
    step(0, 0, 0, 1);
    check("stop_first_tick_ignored", cmds(), 16'h0004);
    step(0, 0, 0, 1);
    check("stop_released", cmds(), 16'h0);

    // Reset mid-COMMIT drops load immediately and restores the shadow
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    check("pre_reset_commit", cmds(), 16'h0010);
    #2 reset = 1'b1;
    #1 check("async_reset_drop", cmds(), 16'h0);
    @(negedge clock);
    reset = 1'b0;
    step(0, 1, 0, 0);
    check("post_reset_shadow", digits(), 16'h2400);
    check("post_reset_alarm_edit", cmds(), 16'h0002);
    step(1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
